// File: rtl/data_mem_responder_if.sv
// rtl/data_mem_responder_if.sv - request/response bus between a load/store requester and the data memory responder
interface data_mem_responder_if;
    logic        req_valid;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        req_ready;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        rsp_ready;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/data_mem_responder.sv
// rtl/data_mem_responder.sv - word-addressed data memory with fixed access latency and valid/ready handshakes
module data_mem_responder #(
    parameter int DEPTH   = 256,
    parameter int LATENCY = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    data_mem_responder_if.slave  bus
);

    localparam int          AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [31:0] DEPTH_W  = 32'(DEPTH);
    localparam logic [3:0]  CNT_INIT = 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        req_ready_q, req_ready_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic [31:0] rsp_rdata_q, rsp_rdata_d;
    logic        rsp_err_q, rsp_err_d;

    logic [31:0] mem [DEPTH];

    logic          accept;
    logic          do_access;
    logic          acc_we;
    logic [31:0]   acc_addr;
    logic [31:0]   acc_wdata;
    logic          acc_in_range;
    logic [AW-1:0] acc_idx;
    logic [31:0]   acc_rdata;
    logic          mem_we;

    // Select the operands of the access: live request when a single-cycle build accesses on acceptance, latched copy otherwise.
    always_comb begin
        accept = (state_q == IDLE) && bus.req_valid && req_ready_q;
        if (state_q == IDLE) begin
            acc_we    = bus.req_we;
            acc_addr  = bus.req_addr;
            acc_wdata = bus.req_wdata;
        end else begin
            acc_we    = we_q;
            acc_addr  = addr_q;
            acc_wdata = wdata_q;
        end
        acc_in_range = (acc_addr < DEPTH_W);
        acc_idx      = acc_addr[AW-1:0];
        do_access    = (LATENCY == 1) ? accept : ((state_q == ACCESS) && (cnt_q == 4'd0));
        mem_we       = do_access && acc_we && acc_in_range;
        acc_rdata    = (!acc_we && acc_in_range) ? mem[acc_idx] : 32'd0;
    end

    // Next-state and next-output logic for the IDLE -> ACCESS -> RESP sequence.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        req_ready_d = req_ready_q;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    we_d        = bus.req_we;
                    addr_d      = bus.req_addr;
                    wdata_d     = bus.req_wdata;
                    cnt_d       = CNT_INIT;
                    req_ready_d = 1'b0;
                    if (LATENCY == 1) begin
                        state_d     = RESP;
                        rsp_valid_d = 1'b1;
                        rsp_rdata_d = acc_rdata;
                        rsp_err_d   = !acc_in_range;
                    end else begin
                        state_d = ACCESS;
                    end
                end
            end
            ACCESS: begin
                if (cnt_q == 4'd0) begin
                    state_d     = RESP;
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = acc_rdata;
                    rsp_err_d   = !acc_in_range;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                // Returning to IDLE here means a request can only be taken on the following edge.
                if (bus.rsp_ready) begin
                    state_d     = IDLE;
                    req_ready_d = 1'b1;
                    rsp_valid_d = 1'b0;
                    rsp_rdata_d = 32'd0;
                    rsp_err_d   = 1'b0;
                end
            end
            default: begin
                state_d     = IDLE;
                cnt_d       = 4'd0;
                req_ready_d = 1'b1;
                rsp_valid_d = 1'b0;
                rsp_rdata_d = 32'd0;
                rsp_err_d   = 1'b0;
            end
        endcase
    end

    // Control state and registered outputs; reset abandons any access in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= 4'd0;
            we_q        <= 1'b0;
            addr_q      <= 32'd0;
            wdata_q     <= 32'd0;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 32'd0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    // Storage array; not reset, and only written on the edge that completes an in-range store.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[acc_idx] <= acc_wdata;
        end
    end

    assign bus.req_ready = req_ready_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// tb/tb_data_mem_responder.sv - self-checking bench for data_mem_responder (latency 2 and latency 1 builds)
module tb_data_mem_responder;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    data_mem_responder_if bus0 ();
    data_mem_responder_if bus1 ();

    data_mem_responder #(.DEPTH(256), .LATENCY(2)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
    data_mem_responder #(.DEPTH(256), .LATENCY(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

    int vectors     = 0;
    int miscompares = 0;

    // Reference memories: index 0 models dut0, index 1 models dut1.
    logic [31:0] mem_model [2][256];
    int          written0 [$];

    // Apply one access to the reference memory and return the response it must produce.
    function automatic void model_apply(input int d, input logic we, input logic [31:0] addr,
                                        input logic [31:0] wdata, output logic [31:0] rd, output logic er);
        er = (addr >= 32'd256);
        rd = 32'd0;
        if (!er) begin
            if (we) mem_model[d][addr[7:0]] = wdata;
            else    rd = mem_model[d][addr[7:0]];
        end
    endfunction

    // Drive one transaction on bus0 and report what was observed; garbage is driven on req_* after acceptance.
    task automatic txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata, input int hold,
                       output int lat, output logic [31:0] rd, output logic er, output logic hold_ok,
                       output logic post_ready, output logic post_valid, output logic [31:0] post_rd,
                       output logic post_er);
        @(negedge clk);
        bus0.req_valid = 1'b1;
        bus0.req_we    = we;
        bus0.req_addr  = addr;
        bus0.req_wdata = wdata;
        bus0.rsp_ready = 1'b0;
        @(negedge clk);
        bus0.req_valid = 1'b0;
        bus0.req_we    = 1'($urandom);
        bus0.req_addr  = $urandom;
        bus0.req_wdata = $urandom;
        lat = 0;
        while (bus0.rsp_valid !== 1'b1 && lat < 40) begin
            bus0.rsp_ready = 1'($urandom);
            bus0.req_valid = 1'($urandom);
            bus0.req_addr  = $urandom;
            bus0.req_wdata = $urandom;
            @(negedge clk);
            lat++;
        end
        bus0.rsp_ready = 1'b0;
        rd      = bus0.rsp_rdata;
        er      = bus0.rsp_err;
        hold_ok = 1'b1;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            if (bus0.rsp_valid !== 1'b1 || bus0.rsp_rdata !== rd || bus0.rsp_err !== er || bus0.req_ready !== 1'b0)
                hold_ok = 1'b0;
        end
        bus0.req_valid = 1'b1;
        bus0.req_addr  = $urandom;
        bus0.rsp_ready = 1'b1;
        @(negedge clk);
        post_ready     = bus0.req_ready;
        post_valid     = bus0.rsp_valid;
        post_rd        = bus0.rsp_rdata;
        post_er        = bus0.rsp_err;
        bus0.req_valid = 1'b0;
        bus0.rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        vectors++;
        if (bus0.req_ready !== 1'b1 || bus0.rsp_valid !== 1'b0 || bus0.rsp_rdata !== 32'd0 || bus0.rsp_err !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_outputs: got ready=%b valid=%b rdata=%h err=%b required 1 0 00000000 0",
                     bus0.req_ready, bus0.rsp_valid, bus0.rsp_rdata, bus0.rsp_err);
        end
        vectors++;
        if (bus1.req_ready !== 1'b1 || bus1.rsp_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_outputs_lat1: got ready=%b valid=%b required 1 0", bus1.req_ready, bus1.rsp_valid);
        end
        rst = 1'b0;
    endtask

    task automatic test_store_load();
        int lat; logic [31:0] rd, prd, erd; logic er, hok, prdy, pv, per, eer;
        txn(1'b1, 32'd5, 32'hDEADBEEF, 0, lat, rd, er, hok, prdy, pv, prd, per);
        model_apply(0, 1'b1, 32'd5, 32'hDEADBEEF, erd, eer);
        vectors++;
        if (lat !== 2) begin miscompares++; $display("FAIL store5_latency: got %0d required 2", lat); end
        vectors++;
        if (rd !== erd || er !== eer) begin
            miscompares++; $display("FAIL store5_rsp: got rdata=%h err=%b required %h %b", rd, er, erd, eer);
        end
        txn(1'b0, 32'd5, 32'h0, 0, lat, rd, er, hok, prdy, pv, prd, per);
        model_apply(0, 1'b0, 32'd5, 32'h0, erd, eer);
        vectors++;
        if (lat !== 2) begin miscompares++; $display("FAIL load5_latency: got %0d required 2", lat); end
        vectors++;
        if (rd !== 32'hDEADBEEF || er !== 1'b0) begin
            miscompares++; $display("FAIL load5_rsp: got rdata=%h err=%b required deadbeef 0", rd, er);
        end
    endtask

    task automatic test_out_of_range();
        int lat; logic [31:0] rd, prd, erd, a0, a255; logic er, hok, prdy, pv, per, eer;
        logic [31:0] addrs [3];
        a0   = $urandom;
        a255 = $urandom;
        txn(1'b1, 32'd0,   a0,   0, lat, rd, er, hok, prdy, pv, prd, per);
        model_apply(0, 1'b1, 32'd0, a0, erd, eer);
        txn(1'b1, 32'd255, a255, 0, lat, rd, er, hok, prdy, pv, prd, per);
        model_apply(0, 1'b1, 32'd255, a255, erd, eer);
        addrs[0] = 32'd256;
        addrs[1] = 32'hFFFF_FFFF;
        addrs[2] = 32'd256;
        for (int i = 0; i < 3; i++) begin
            logic w;
            w = (i == 2);
            txn(w, addrs[i], 32'hA5A5_0000 | 32'(i), 0, lat, rd, er, hok, prdy, pv, prd, per);
            model_apply(0, w, addrs[i], 32'hA5A5_0000 | 32'(i), erd, eer);
            vectors++;
            if (rd !== 32'd0 || er !== 1'b1 || eer !== 1'b1) begin
                miscompares++;
                $display("FAIL oor_rsp_%0d: addr=%h got rdata=%h err=%b required 00000000 1", i, addrs[i], rd, er);
            end
        end
        txn(1'b0, 32'd0, 32'd0, 0, lat, rd, er, hok, prdy, pv, prd, per);
        vectors++;
        if (rd !== a0 || er !== 1'b0) begin
            miscompares++; $display("FAIL oor_check_addr0: got rdata=%h err=%b required %h 0", rd, er, a0);
        end
        txn(1'b0, 32'd255, 32'd0, 0, lat, rd, er, hok, prdy, pv, prd, per);
        vectors++;
        if (rd !== a255 || er !== 1'b0) begin
            miscompares++; $display("FAIL oor_check_addr255: got rdata=%h err=%b required %h 0", rd, er, a255);
        end
    endtask

    task automatic test_backpressure();
        int lat; logic [31:0] rd, prd, erd, d; logic er, hok, prdy, pv, per, eer;
        d = $urandom;
        txn(1'b1, 32'd9, d, 0, lat, rd, er, hok, prdy, pv, prd, per);
        model_apply(0, 1'b1, 32'd9, d, erd, eer);
        txn(1'b0, 32'd9, 32'd0, 5, lat, rd, er, hok, prdy, pv, prd, per);
        model_apply(0, 1'b0, 32'd9, 32'd0, erd, eer);
        vectors++;
        if (rd !== erd || er !== 1'b0) begin
            miscompares++; $display("FAIL bp_rdata: got %h err=%b required %h 0", rd, er, erd);
        end
        vectors++;
        if (hok !== 1'b1) begin miscompares++; $display("FAIL bp_hold_stable: got %b required 1", hok); end
        vectors++;
        if (prdy !== 1'b1 || pv !== 1'b0) begin
            miscompares++; $display("FAIL bp_after_handshake: got ready=%b valid=%b required 1 0", prdy, pv);
        end
        vectors++;
        if (prd !== 32'd0 || per !== 1'b0) begin
            miscompares++; $display("FAIL bp_cleared: got rdata=%h err=%b required 00000000 0", prd, per);
        end
    endtask

    task automatic test_reset_in_access();
        int lat; logic [31:0] rd, prd, erd; logic er, hok, prdy, pv, per, eer;
        logic saw_valid;
        txn(1'b1, 32'd7, 32'd0, 0, lat, rd, er, hok, prdy, pv, prd, per);
        model_apply(0, 1'b1, 32'd7, 32'd0, erd, eer);
        @(negedge clk);
        bus0.req_valid = 1'b1;
        bus0.req_we    = 1'b1;
        bus0.req_addr  = 32'd7;
        bus0.req_wdata = 32'h1234;
        bus0.rsp_ready = 1'b0;
        @(negedge clk);
        bus0.req_valid = 1'b0;
        bus0.req_addr  = $urandom;
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        vectors++;
        if (bus0.req_ready !== 1'b1 || bus0.rsp_valid !== 1'b0 || bus0.rsp_rdata !== 32'd0 || bus0.rsp_err !== 1'b0) begin
            miscompares++;
            $display("FAIL async_reset_outputs: got ready=%b valid=%b rdata=%h err=%b required 1 0 00000000 0",
                     bus0.req_ready, bus0.rsp_valid, bus0.rsp_rdata, bus0.rsp_err);
        end
        @(negedge clk);
        rst = 1'b0;
        saw_valid = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (bus0.rsp_valid !== 1'b0) saw_valid = 1'b1;
        end
        vectors++;
        if (saw_valid !== 1'b0) begin miscompares++; $display("FAIL no_rsp_after_reset: got %b required 0", saw_valid); end
        txn(1'b0, 32'd7, 32'd0, 0, lat, rd, er, hok, prdy, pv, prd, per);
        model_apply(0, 1'b0, 32'd7, 32'd0, erd, eer);
        vectors++;
        if (rd !== erd || er !== 1'b0) begin
            miscompares++; $display("FAIL store_discarded_addr7: got %h required %h", rd, erd);
        end
    endtask

    task automatic test_random();
        int lat; logic [31:0] rd, prd, erd, addr, wdata; logic er, hok, prdy, pv, per, eer, we;
        int r, hold;
        written0 = {5, 0, 255, 9, 7};
        for (int i = 0; i < 30; i++) begin
            r = int'($urandom % 6);
            if (r == 0) begin
                we   = 1'($urandom);
                addr = $urandom;
                if (addr < 32'd256) addr = addr + 32'd256;
            end else if (r < 3) begin
                we   = 1'b1;
                addr = $urandom % 256;
            end else begin
                we   = 1'b0;
                addr = 32'(written0[$urandom % written0.size()]);
            end
            wdata = $urandom;
            hold  = int'($urandom % 3);
            txn(we, addr, wdata, hold, lat, rd, er, hok, prdy, pv, prd, per);
            model_apply(0, we, addr, wdata, erd, eer);
            if (we && !eer) written0.push_back(int'(addr));
            vectors++;
            if (lat !== 2) begin miscompares++; $display("FAIL rnd%0d_latency: got %0d required 2", i, lat); end
            vectors++;
            if (rd !== erd || er !== eer) begin
                miscompares++;
                $display("FAIL rnd%0d_rsp: we=%b addr=%h got rdata=%h err=%b required %h %b", i, we, addr, rd, er, erd, eer);
            end
            vectors++;
            if (hok !== 1'b1) begin miscompares++; $display("FAIL rnd%0d_hold: got %b required 1", i, hok); end
            vectors++;
            if (prdy !== 1'b1 || pv !== 1'b0) begin
                miscompares++; $display("FAIL rnd%0d_handshake: got ready=%b valid=%b required 1 0", i, prdy, pv);
            end
        end
    endtask

    task automatic test_latency1_back_to_back();
        logic        op_we [$];
        logic [31:0] op_addr [$];
        logic [31:0] op_wd [$];
        logic [31:0] exp_rd [$];
        logic        exp_er [$];
        logic [31:0] erd; logic eer;
        int n, idx, got, last, cyc;
        for (int i = 0; i < 8; i++) begin
            op_we.push_back(1'b1);
            op_addr.push_back(32'(i * 31 + ($urandom % 16)));
            op_wd.push_back($urandom);
        end
        for (int i = 0; i < 8; i++) begin
            op_we.push_back(1'b0);
            op_addr.push_back(op_addr[7 - i]);
            op_wd.push_back($urandom);
        end
        op_we.push_back(1'b0);
        op_addr.push_back(32'd300);
        op_wd.push_back(32'd0);
        n    = op_we.size();
        idx  = 0;
        got  = 0;
        last = -1;
        cyc  = 0;
        @(negedge clk);
        while (got < n && cyc < 200) begin
            if (bus1.rsp_valid === 1'b1) begin
                vectors++;
                if (bus1.rsp_rdata !== exp_rd[got] || bus1.rsp_err !== exp_er[got]) begin
                    miscompares++;
                    $display("FAIL lat1_rsp%0d: got rdata=%h err=%b required %h %b",
                             got, bus1.rsp_rdata, bus1.rsp_err, exp_rd[got], exp_er[got]);
                end
                if (last >= 0) begin
                    vectors++;
                    if (cyc - last !== 2) begin
                        miscompares++; $display("FAIL lat1_spacing%0d: got %0d cycles required 2", got, cyc - last);
                    end
                end
                last = cyc;
                got++;
            end
            if (bus1.req_ready === 1'b1) begin
                if (idx < n) begin
                    bus1.req_valid = 1'b1;
                    bus1.req_we    = op_we[idx];
                    bus1.req_addr  = op_addr[idx];
                    bus1.req_wdata = op_wd[idx];
                    model_apply(1, op_we[idx], op_addr[idx], op_wd[idx], erd, eer);
                    exp_rd.push_back(erd);
                    exp_er.push_back(eer);
                    idx++;
                end else begin
                    bus1.req_valid = 1'b0;
                end
            end
            @(negedge clk);
            cyc++;
        end
        bus1.req_valid = 1'b0;
        vectors++;
        if (got !== n) begin miscompares++; $display("FAIL lat1_response_count: got %0d required %0d", got, n); end
    endtask

    initial begin
        rst            = 1'b1;
        bus0.req_valid = 1'b0;
        bus0.req_we    = 1'b0;
        bus0.req_addr  = 32'd0;
        bus0.req_wdata = 32'd0;
        bus0.rsp_ready = 1'b0;
        bus1.req_valid = 1'b0;
        bus1.req_we    = 1'b0;
        bus1.req_addr  = 32'd0;
        bus1.req_wdata = 32'd0;
        bus1.rsp_ready = 1'b1;
        test_reset();
        test_store_load();
        test_out_of_range();
        test_backpressure();
        test_reset_in_access();
        test_random();
        test_latency1_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 SHALL have parameter DEPTH, default 256, number of 32-bit words in the array.
REQ-002 SHALL have parameter LATENCY, default 2, cycles from request acceptance to response (legal range 1..15).
REQ-003 SHALL have port clk, input, 1, single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1, reset, asynchronous and active-high.
REQ-005 SHALL have port req_valid, input, 1, a load/store request is presented.
REQ-006 SHALL have port req_we, input, 1, 1 = store (sw), 0 = load (lw).
REQ-007 SHALL have port req_addr, input, 32, word address (base + sign-extended offset, already summed by the requester).
REQ-008 SHALL have port req_wdata, input, 32, store data.
REQ-009 SHALL have port req_ready, output, 1, responder can accept a request.
REQ-010 SHALL have port rsp_valid, output, 1, a response is presented.
REQ-011 SHALL have port rsp_rdata, output, 32, load data; 0 for stores and errors.
REQ-012 SHALL have port rsp_err, output, 1, the address was out of range (req_addr >= DEPTH).
REQ-013 SHALL have port rsp_ready, input, 1, the requester accepts the response.

Function
REQ-014 SHALL implement the FSM states IDLE, ACCESS and RESP.
REQ-015 SHALL drive req_ready = 1 only in IDLE and rsp_valid = 1 only in RESP.
REQ-016 SHALL accept a request on an edge where the state is IDLE, req_valid = 1 and req_ready = 1.
REQ-017 SHALL, on acceptance, latch we, addr and wdata, load a latency counter with LATENCY-1 and go to ACCESS.
REQ-018 SHALL ignore later changes on the req_* inputs until the next acceptance.
REQ-019 SHALL, in ACCESS, decrement the counter each cycle and, when the counter is 0, perform the access and go to RESP.
REQ-020 SHALL raise rsp_valid exactly LATENCY cycles after the accepting edge.
REQ-021 SHALL, for an in-range load, register the value mem[addr] into rsp_rdata on the edge entering RESP, with rsp_err = 0.
REQ-022 SHALL, for an in-range store, write wdata to mem[addr] on the edge entering RESP, with rsp_rdata = 0 and rsp_err = 0.
REQ-023 SHALL, for an out-of-range access (addr >= DEPTH, compared over all 32 bits, no wrap-around), leave the array unmodified and return rsp_rdata = 0 and rsp_err = 1.
REQ-024 SHALL hold rsp_valid, rsp_rdata and rsp_err stable in RESP until rsp_ready = 1.
REQ-025 SHALL, on an edge in RESP with rsp_ready = 1, go to IDLE and clear rsp_rdata and rsp_err.
REQ-026 SHALL not accept a new request on the response-handshake edge; the earliest new acceptance is one cycle later.
REQ-027 SHALL ignore rsp_ready outside RESP.
REQ-028 SHALL return the newly stored data when a load follows a store to the same address.
REQ-029 SHALL, when LATENCY = 1, go from IDLE directly to RESP with no cycle spent in ACCESS.

Reset
REQ-030 SHALL, while rst = 1, immediately force state = IDLE, req_ready = 1, rsp_valid = 0, rsp_rdata = 0, rsp_err = 0 and counter = 0.
REQ-031 SHALL, on reset during ACCESS, discard the pending store so the array is unmodified and produce no response after reset.
REQ-032 SHALL leave array contents unaffected by reset; contents are undefined until written.

Verification
REQ-033 SHALL cover: store addr 5 data 0xDEADBEEF, then load addr 5 -> rsp_rdata = 0xDEADBEEF, rsp_err = 0, rsp_valid rising 2 cycles after each acceptance.
REQ-034 SHALL cover: load addr 256 (and addr 0xFFFFFFFF) -> rsp_err = 1, rsp_rdata = 0; then store addr 256 -> array unchanged, verified by loading addr 0 and addr 255.
REQ-035 SHALL cover: rsp_ready held 0 for 5 cycles after a load -> rsp_valid and rsp_rdata stable all 5 cycles, req_ready = 0 throughout, and req_ready = 1 the cycle after the handshake.
REQ-036 SHALL cover: store addr 7 data 0x1234 accepted, rst pulsed 1 cycle later (asynchronous, mid-cycle) -> outputs at reset values immediately, no rsp_valid afterwards, and a later load of addr 7 does not return 0x1234 (addr 7 preloaded with 0).
REQ-037 SHALL cover: LATENCY = 1 build, back-to-back loads with rsp_ready tied to 1 -> one response per 2 cycles, correct data each time.
REQ-038 SHALL cover: req_addr/req_wdata changed during ACCESS -> the store commits the originally latched address and data.
